// File: rtl/regfile_scoreboard_pkg.sv
// Shared sizing and writeback-source encoding
// for the register scoreboard and writeback arbiter.
package regfile_scoreboard_pkg;

    localparam int WORD_SIZE    = 16;
    localparam int NUM_REGS     = 4;
    localparam int REG_AW       = 2;
    localparam int STARVE_LIMIT = 2;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_MEM,
        WB_ALU_DIRECT,
        WB_ALU_BUF
    } wb_src_e;

endpackage

// File: rtl/regfile_scoreboard_wb_arbiter.sv
// Writeback arbiter: one-entry ALU buffer with
// age-based starvation guard against memory.
module wb_arbiter #(
    parameter int WORD_SIZE    = regfile_scoreboard_pkg::WORD_SIZE,
    parameter int STARVE_LIMIT = regfile_scoreboard_pkg::STARVE_LIMIT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 alu_wb_valid,
    output logic                 alu_wb_ready,
    input  logic [1:0]           alu_wb_reg,
    input  logic [WORD_SIZE-1:0] alu_wb_data,
    input  logic                 mem_wb_valid,
    output logic                 mem_wb_ready,
    input  logic [1:0]           mem_wb_reg,
    input  logic [WORD_SIZE-1:0] mem_wb_data,
    output logic                 rf_write,
    output logic [1:0]           rf_wreg,
    output logic [WORD_SIZE-1:0] rf_wdata
);
    import regfile_scoreboard_pkg::*;

    logic                 buf_valid_q, buf_valid_d;
    logic [1:0]           buf_reg_q, buf_reg_d;
    logic [WORD_SIZE-1:0] buf_data_q, buf_data_d;
    logic [7:0]           age_q, age_d;
    logic                 starved;
    wb_src_e              src;

    // Pick the port winner, drive the write port, and plan buffer/age.
    always_comb begin
        starved      = buf_valid_q && (age_q >= 8'(STARVE_LIMIT));
        alu_wb_ready = reset_n && !buf_valid_q;
        mem_wb_ready = reset_n && !starved;
        src          = WB_NONE;
        if (!reset_n)
            src = WB_NONE;
        else if (starved)
            src = WB_ALU_BUF;
        else if (mem_wb_valid)
            src = WB_MEM;
        else if (buf_valid_q)
            src = WB_ALU_BUF;
        else if (alu_wb_valid)
            src = WB_ALU_DIRECT;

        rf_write = 1'b0;
        rf_wreg  = '0;
        rf_wdata = '0;
        case (src)
            WB_MEM: begin
                rf_write = 1'b1;
                rf_wreg  = mem_wb_reg;
                rf_wdata = mem_wb_data;
            end
            WB_ALU_DIRECT: begin
                rf_write = 1'b1;
                rf_wreg  = alu_wb_reg;
                rf_wdata = alu_wb_data;
            end
            WB_ALU_BUF: begin
                rf_write = 1'b1;
                rf_wreg  = buf_reg_q;
                rf_wdata = buf_data_q;
            end
            default: ;
        endcase

        buf_valid_d = buf_valid_q;
        buf_reg_d   = buf_reg_q;
        buf_data_d  = buf_data_q;
        age_d       = age_q;
        if (src == WB_ALU_BUF) begin
            buf_valid_d = 1'b0;
            age_d       = '0;
        end else if (buf_valid_q) begin
            if (age_q != 8'hFF)
                age_d = age_q + 8'd1;
        end else if (alu_wb_valid && alu_wb_ready
                     && src != WB_ALU_DIRECT) begin
            buf_valid_d = 1'b1;
            buf_reg_d   = alu_wb_reg;
            buf_data_d  = alu_wb_data;
            age_d       = '0;
        end
    end

    // Buffer and age registers; reset drops any held entry.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            buf_valid_q <= 1'b0;
            buf_reg_q   <= '0;
            buf_data_q  <= '0;
            age_q       <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_reg_q   <= buf_reg_d;
            buf_data_q  <= buf_data_d;
            age_q       <= age_d;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register scoreboard: tracks outstanding writes,
// gates issue on RAW/WAW, counts stalls.
module regfile_scoreboard #(
    parameter int WORD_SIZE    = regfile_scoreboard_pkg::WORD_SIZE,
    parameter int NUM_REGS     = regfile_scoreboard_pkg::NUM_REGS,
    parameter int STARVE_LIMIT = regfile_scoreboard_pkg::STARVE_LIMIT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 iss_valid,
    output logic                 iss_ready,
    input  logic                 iss_use_rs1,
    input  logic [1:0]           iss_rs1,
    input  logic                 iss_use_rs2,
    input  logic [1:0]           iss_rs2,
    input  logic                 iss_wr,
    input  logic [1:0]           iss_rd,
    input  logic                 alu_wb_valid,
    output logic                 alu_wb_ready,
    input  logic [1:0]           alu_wb_reg,
    input  logic [WORD_SIZE-1:0] alu_wb_data,
    input  logic                 mem_wb_valid,
    output logic                 mem_wb_ready,
    input  logic [1:0]           mem_wb_reg,
    input  logic [WORD_SIZE-1:0] mem_wb_data,
    output logic                 rf_write,
    output logic [1:0]           rf_wreg,
    output logic [WORD_SIZE-1:0] rf_wdata,
    output logic [NUM_REGS-1:0]  pending,
    output logic [15:0]          stall_cnt,
    output logic                 wb_err
);
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [15:0]         stall_cnt_q, stall_cnt_d;
    logic                wb_err_q, wb_err_d;
    logic                busy1, busy2, waw, issue;

    wb_arbiter #(
        .WORD_SIZE    (WORD_SIZE),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk          (clk),
        .reset_n      (reset_n),
        .alu_wb_valid (alu_wb_valid),
        .alu_wb_ready (alu_wb_ready),
        .alu_wb_reg   (alu_wb_reg),
        .alu_wb_data  (alu_wb_data),
        .mem_wb_valid (mem_wb_valid),
        .mem_wb_ready (mem_wb_ready),
        .mem_wb_reg   (mem_wb_reg),
        .mem_wb_data  (mem_wb_data),
        .rf_write     (rf_write),
        .rf_wreg      (rf_wreg),
        .rf_wdata     (rf_wdata)
    );

    // Hazard check with same-cycle writeback bypass, then state update.
    always_comb begin
        busy1 = iss_use_rs1 && pending_q[iss_rs1]
                && !(rf_write && rf_wreg == iss_rs1);
        busy2 = iss_use_rs2 && pending_q[iss_rs2]
                && !(rf_write && rf_wreg == iss_rs2);
        waw   = iss_wr && pending_q[iss_rd]
                && !(rf_write && rf_wreg == iss_rd);
        iss_ready = reset_n && !busy1 && !busy2 && !waw;
        issue     = iss_valid && iss_ready;

        pending_d = pending_q;
        if (rf_write)
            pending_d[rf_wreg] = 1'b0;
        if (issue && iss_wr)
            pending_d[iss_rd] = 1'b1;

        wb_err_d = wb_err_q || (rf_write && !pending_q[rf_wreg]);

        stall_cnt_d = stall_cnt_q;
        if (iss_valid && !iss_ready && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // Scoreboard, error flag and stall counter registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending_q   <= '0;
            stall_cnt_q <= '0;
            wb_err_q    <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
            wb_err_q    <= wb_err_d;
        end
    end

    assign pending   = pending_q;
    assign stall_cnt = stall_cnt_q;
    assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard:
// hazards, arbitration, starvation, error flag, reset.
module tb_regfile_scoreboard;

    logic        clk;
    logic        reset_n;
    logic        iss_valid, iss_ready;
    logic        iss_use_rs1, iss_use_rs2, iss_wr;
    logic [1:0]  iss_rs1, iss_rs2, iss_rd;
    logic        alu_wb_valid, alu_wb_ready;
    logic [1:0]  alu_wb_reg;
    logic [15:0] alu_wb_data;
    logic        mem_wb_valid, mem_wb_ready;
    logic [1:0]  mem_wb_reg;
    logic [15:0] mem_wb_data;
    logic        rf_write;
    logic [1:0]  rf_wreg;
    logic [15:0] rf_wdata;
    logic [3:0]  pending;
    logic [15:0] stall_cnt;
    logic        wb_err;

    int n_vec = 0;
    int n_err = 0;

    regfile_scoreboard dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .iss_valid    (iss_valid),
        .iss_ready    (iss_ready),
        .iss_use_rs1  (iss_use_rs1),
        .iss_rs1      (iss_rs1),
        .iss_use_rs2  (iss_use_rs2),
        .iss_rs2      (iss_rs2),
        .iss_wr       (iss_wr),
        .iss_rd       (iss_rd),
        .alu_wb_valid (alu_wb_valid),
        .alu_wb_ready (alu_wb_ready),
        .alu_wb_reg   (alu_wb_reg),
        .alu_wb_data  (alu_wb_data),
        .mem_wb_valid (mem_wb_valid),
        .mem_wb_ready (mem_wb_ready),
        .mem_wb_reg   (mem_wb_reg),
        .mem_wb_data  (mem_wb_data),
        .rf_write     (rf_write),
        .rf_wreg      (rf_wreg),
        .rf_wdata     (rf_wdata),
        .pending      (pending),
        .stall_cnt    (stall_cnt),
        .wb_err       (wb_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle();
        iss_valid    = 0; iss_use_rs1 = 0; iss_rs1 = 0;
        iss_use_rs2  = 0; iss_rs2     = 0;
        iss_wr       = 0; iss_rd      = 0;
        alu_wb_valid = 0; alu_wb_reg  = 0; alu_wb_data = 0;
        mem_wb_valid = 0; mem_wb_reg  = 0; mem_wb_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_wr(input logic [1:0] rd);
        idle();
        iss_valid = 1; iss_wr = 1; iss_rd = rd;
        tick();
    endtask

    task automatic test_reset();
        idle();
        reset_n = 0;
        iss_valid = 1; alu_wb_valid = 1; mem_wb_valid = 1;
        #1;
        n_vec++;
        if ({iss_ready, alu_wb_ready, mem_wb_ready, rf_write} !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_outs got %b want 0000",
                     {iss_ready, alu_wb_ready, mem_wb_ready, rf_write});
        end
        tick();
        reset_n = 1;
        idle();
        #1;
        n_vec++;
        if ({pending, stall_cnt, wb_err} !== 21'd0) begin
            n_err++;
            $display("FAIL rst_state got p=%b s=%0d e=%b want 0",
                     pending, stall_cnt, wb_err);
        end
        n_vec++;
        if ({iss_ready, alu_wb_ready, mem_wb_ready, rf_write} !== 4'b1110) begin
            n_err++;
            $display("FAIL rst_idle got %b want 1110",
                     {iss_ready, alu_wb_ready, mem_wb_ready, rf_write});
        end
    endtask

    task automatic test_raw();
        idle();
        iss_valid = 1; iss_wr = 1; iss_rd = 2;
        #1;
        n_vec++;
        if (iss_ready !== 1'b1) begin
            n_err++;
            $display("FAIL raw_first_ready got %b want 1", iss_ready);
        end
        tick();
        n_vec++;
        if (pending !== 4'b0100) begin
            n_err++;
            $display("FAIL raw_pend got %b want 0100", pending);
        end
        idle();
        iss_valid = 1; iss_use_rs1 = 1; iss_rs1 = 2;
        #1;
        n_vec++;
        if (iss_ready !== 1'b0) begin
            n_err++;
            $display("FAIL raw_rs1_busy got %b want 0", iss_ready);
        end
        tick();
        n_vec++;
        if (stall_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL raw_stall1 got %0d want 1", stall_cnt);
        end
        idle();
        iss_valid = 1; iss_use_rs2 = 1; iss_rs2 = 2;
        #1;
        n_vec++;
        if (iss_ready !== 1'b0) begin
            n_err++;
            $display("FAIL raw_rs2_busy got %b want 0", iss_ready);
        end
        tick();
        n_vec++;
        if (stall_cnt !== 16'd2) begin
            n_err++;
            $display("FAIL raw_stall2 got %0d want 2", stall_cnt);
        end
        idle();
        iss_valid = 1; iss_use_rs1 = 1; iss_rs1 = 2;
        alu_wb_valid = 1; alu_wb_reg = 2; alu_wb_data = 16'h1234;
        #1;
        n_vec++;
        if ({iss_ready, rf_write, rf_wreg, rf_wdata} !== {1'b1, 1'b1, 2'd2, 16'h1234}) begin
            n_err++;
            $display("FAIL raw_bypass got rdy=%b w=%b r=%0d d=%h want 1 1 2 1234",
                     iss_ready, rf_write, rf_wreg, rf_wdata);
        end
        tick();
        idle();
        #1;
        n_vec++;
        if ({pending, stall_cnt, wb_err} !== {4'b0000, 16'd2, 1'b0}) begin
            n_err++;
            $display("FAIL raw_after got p=%b s=%0d e=%b want 0000 2 0",
                     pending, stall_cnt, wb_err);
        end
    endtask

    task automatic test_collision();
        issue_wr(2'd1);
        issue_wr(2'd3);
        idle();
        alu_wb_valid = 1; alu_wb_reg = 1; alu_wb_data = 16'hAAAA;
        mem_wb_valid = 1; mem_wb_reg = 3; mem_wb_data = 16'h5555;
        #1;
        n_vec++;
        if ({rf_write, rf_wreg, rf_wdata, alu_wb_ready, mem_wb_ready}
            !== {1'b1, 2'd3, 16'h5555, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL coll_mem got w=%b r=%0d d=%h ar=%b mr=%b want 1 3 5555 1 1",
                     rf_write, rf_wreg, rf_wdata, alu_wb_ready, mem_wb_ready);
        end
        tick();
        idle();
        #1;
        n_vec++;
        if ({rf_write, rf_wreg, rf_wdata, alu_wb_ready}
            !== {1'b1, 2'd1, 16'hAAAA, 1'b0}) begin
            n_err++;
            $display("FAIL coll_buf got w=%b r=%0d d=%h ar=%b want 1 1 aaaa 0",
                     rf_write, rf_wreg, rf_wdata, alu_wb_ready);
        end
        tick();
        n_vec++;
        if ({alu_wb_ready, rf_write, pending, wb_err} !== {1'b1, 1'b0, 4'b0000, 1'b0}) begin
            n_err++;
            $display("FAIL coll_after got ar=%b w=%b p=%b e=%b want 1 0 0000 0",
                     alu_wb_ready, rf_write, pending, wb_err);
        end
    endtask

    task automatic test_wb_err();
        idle();
        mem_wb_valid = 1; mem_wb_reg = 2; mem_wb_data = 16'h0BAD;
        #1;
        n_vec++;
        if ({wb_err, rf_write, rf_wreg} !== {1'b0, 1'b1, 2'd2}) begin
            n_err++;
            $display("FAIL err_write got e=%b w=%b r=%0d want 0 1 2",
                     wb_err, rf_write, rf_wreg);
        end
        tick();
        idle();
        #1;
        n_vec++;
        if (wb_err !== 1'b1) begin
            n_err++;
            $display("FAIL err_set got %b want 1", wb_err);
        end
        tick();
        tick();
        n_vec++;
        if (wb_err !== 1'b1) begin
            n_err++;
            $display("FAIL err_sticky got %b want 1", wb_err);
        end
    endtask

    task automatic test_starve();
        idle();
        alu_wb_valid = 1; alu_wb_reg = 0; alu_wb_data = 16'h0F0F;
        mem_wb_valid = 1; mem_wb_reg = 3; mem_wb_data = 16'h1111;
        #1;
        n_vec++;
        if ({rf_wreg, alu_wb_ready} !== {2'd3, 1'b1}) begin
            n_err++;
            $display("FAIL stv_cap got r=%0d ar=%b want 3 1", rf_wreg, alu_wb_ready);
        end
        tick();
        alu_wb_valid = 0;
        for (int c = 1; c <= 2; c++) begin
            #1;
            n_vec++;
            if ({alu_wb_ready, mem_wb_ready, rf_write, rf_wreg}
                !== {1'b0, 1'b1, 1'b1, 2'd3}) begin
                n_err++;
                $display("FAIL stv_wait%0d got ar=%b mr=%b w=%b r=%0d want 0 1 1 3",
                         c, alu_wb_ready, mem_wb_ready, rf_write, rf_wreg);
            end
            tick();
        end
        #1;
        n_vec++;
        if ({mem_wb_ready, rf_write, rf_wreg, rf_wdata}
            !== {1'b0, 1'b1, 2'd0, 16'h0F0F}) begin
            n_err++;
            $display("FAIL stv_drain got mr=%b w=%b r=%0d d=%h want 0 1 0 0f0f",
                     mem_wb_ready, rf_write, rf_wreg, rf_wdata);
        end
        tick();
        n_vec++;
        if ({mem_wb_ready, alu_wb_ready, rf_wreg} !== {1'b1, 1'b1, 2'd3}) begin
            n_err++;
            $display("FAIL stv_after got mr=%b ar=%b r=%0d want 1 1 3",
                     mem_wb_ready, alu_wb_ready, rf_wreg);
        end
        idle();
        tick();
    endtask

    task automatic test_waw();
        issue_wr(2'd0);
        n_vec++;
        if (pending !== 4'b0001) begin
            n_err++;
            $display("FAIL waw_pend got %b want 0001", pending);
        end
        idle();
        iss_valid = 1; iss_wr = 1; iss_rd = 0;
        #1;
        n_vec++;
        if (iss_ready !== 1'b0) begin
            n_err++;
            $display("FAIL waw_block got %b want 0", iss_ready);
        end
        alu_wb_valid = 1; alu_wb_reg = 0; alu_wb_data = 16'h7777;
        #1;
        n_vec++;
        if ({iss_ready, rf_write} !== 2'b11) begin
            n_err++;
            $display("FAIL waw_bypass got %b want 11", {iss_ready, rf_write});
        end
        tick();
        idle();
        #1;
        n_vec++;
        if (pending !== 4'b0001) begin
            n_err++;
            $display("FAIL waw_setwins got %b want 0001", pending);
        end
        alu_wb_valid = 1; alu_wb_reg = 0;
        tick();
        idle();
        n_vec++;
        if (pending !== 4'b0000) begin
            n_err++;
            $display("FAIL waw_clear got %b want 0000", pending);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        reset_n = 0;
        tick();
        reset_n = 1;
        issue_wr(2'd0);
        issue_wr(2'd1);
        issue_wr(2'd3);
        for (int c = 0; c < 5; c++) begin
            idle();
            iss_valid = 1; iss_wr = 1; iss_rd = 1;
            tick();
        end
        idle();
        alu_wb_valid = 1; alu_wb_reg = 0; alu_wb_data = 16'hBEEF;
        mem_wb_valid = 1; mem_wb_reg = 2; mem_wb_data = 16'h2222;
        tick();
        alu_wb_valid = 0;
        #1;
        n_vec++;
        if ({pending, stall_cnt, alu_wb_ready, rf_wreg}
            !== {4'b1011, 16'd5, 1'b0, 2'd2}) begin
            n_err++;
            $display("FAIL mid_pre got p=%b s=%0d ar=%b r=%0d want 1011 5 0 2",
                     pending, stall_cnt, alu_wb_ready, rf_wreg);
        end
        tick();
        idle();
        reset_n = 0;
        #1;
        n_vec++;
        if ({rf_write, alu_wb_ready, mem_wb_ready, iss_ready} !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_in_rst got %b want 0000",
                     {rf_write, alu_wb_ready, mem_wb_ready, iss_ready});
        end
        tick();
        reset_n = 1;
        #1;
        n_vec++;
        if ({pending, stall_cnt, wb_err, rf_write, alu_wb_ready}
            !== {4'b0000, 16'd0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL mid_after got p=%b s=%0d e=%b w=%b ar=%b want 0 0 0 0 1",
                     pending, stall_cnt, wb_err, rf_write, alu_wb_ready);
        end
        tick();
        n_vec++;
        if (rf_write !== 1'b0) begin
            n_err++;
            $display("FAIL mid_no_drain got %b want 0", rf_write);
        end
    endtask

    initial begin
        reset_n = 0;
        idle();
        #1;
        test_reset();
        test_raw();
        test_collision();
        test_wb_err();
        test_starve();
        test_waw();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
